// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one combinational ALU; 1-cycle result latency.
// A port is not granted while its response slot is full and not draining.

module alu #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ovf
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (opcode)
      OP_ADD: begin
        res = a + b;
        // Signed overflow: like-signed operands producing an opposite-signed sum.
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
    zero = (res == '0);
  end

endmodule

module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_opcode0,
  input  logic [2:0]       req_opcode1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_res0,
  output logic [WIDTH-1:0] rsp_res1,
  output logic [1:0]       rsp_zero,
  output logic [1:0]       rsp_ovf,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ovf;
  } alu_rsp_t;

  alu_req_t         req_dat [2];
  alu_req_t         sel_dat;
  alu_rsp_t         alu_dat;
  alu_rsp_t         rsp_dat [2];
  logic [1:0]       rsp_vld;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  assign req_dat[0] = '{opcode: req_opcode0, a: req_a0, b: req_b0};
  assign req_dat[1] = '{opcode: req_opcode1, a: req_a1, b: req_b1};

  // A full slot that is being consumed this cycle can accept a new result.
  assign elig = req_valid & (~rsp_vld | rsp_ready);

  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (elig == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else               grant = elig;
    end
  end

  assign req_ready = grant;
  assign sel_dat   = grant[1] ? req_dat[1] : req_dat[0];

  alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (sel_dat.opcode),
    .a      (sel_dat.a),
    .b      (sel_dat.b),
    .res    (alu_dat.res),
    .zero   (alu_dat.zero),
    .ovf    (alu_dat.ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cnt        <= '0;
    end else if (|grant) begin
      last_grant <= grant[1];
      cnt        <= cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_vld[i] <= 1'b0;
        rsp_dat[i] <= '0;
      end else if (grant[i]) begin
        rsp_vld[i] <= 1'b1;
        rsp_dat[i] <= alu_dat;
      end else if (rsp_ready[i]) begin
        rsp_vld[i] <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_vld;
  assign rsp_res0  = rsp_dat[0].res;
  assign rsp_res1  = rsp_dat[1].res;
  assign rsp_zero  = {rsp_dat[1].zero, rsp_dat[0].zero};
  assign rsp_ovf   = {rsp_dat[1].ovf, rsp_dat[0].ovf};
  assign op_count  = cnt;

endmodule
